// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: lane request/grant/read-return signals of both issue lanes
// together with the single data-memory port. The master side is the pipeline
// and memory environment; the slave side is the arbiter.
interface dm_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_gnt;
  logic          p0_rvalid;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_gnt;
  logic          p1_rvalid;
  logic [DW-1:0] p1_rdata;

  logic          stall;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  stall, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output stall, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: serializes the two issue lanes onto a single-port synchronous
// data memory, p0 before p1. A two-request bundle costs one stall cycle and
// is counted in a saturating conflict counter.
// Optional feature: define DM_ARB_MERGE_EN to merge same-address bundles of
// the same direction (both reads or both writes) into one memory access.
module dm_arbiter #(
  parameter int AW    = 9,
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  dm_arbiter_if.slave      bus,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t        state;
  logic          both_req;
  logic          merge_ok;
  logic          p0_gnt_c;
  logic          p1_gnt_c;
  logic          stall_c;
  logic          we_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wdata_c;
  logic          p0_pend;
  logic          p1_pend;
  logic [DW-1:0] p0_rdata_q;
  logic [DW-1:0] p1_rdata_q;

  assign both_req = bus.p0_req && bus.p1_req;

`ifdef DM_ARB_MERGE_EN
  assign merge_ok = (bus.p0_addr == bus.p1_addr) && (bus.p0_we == bus.p1_we);
`else
  assign merge_ok = 1'b0;
`endif

  // Grant and memory-port selection from current state and requests; all
  // forced low while reset is asserted.
  always_comb begin
    p0_gnt_c = 1'b0;
    p1_gnt_c = 1'b0;
    stall_c  = 1'b0;
    we_c     = 1'b0;
    addr_c   = '0;
    wdata_c  = '0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (both_req) begin
            p0_gnt_c = 1'b1;
            addr_c   = bus.p0_addr;
            we_c     = bus.p0_we;
            if (merge_ok) begin
              p1_gnt_c = 1'b1;
              wdata_c  = bus.p1_wdata;
            end else begin
              stall_c  = 1'b1;
              wdata_c  = bus.p0_wdata;
            end
          end else if (bus.p0_req) begin
            p0_gnt_c = 1'b1;
            addr_c   = bus.p0_addr;
            we_c     = bus.p0_we;
            wdata_c  = bus.p0_wdata;
          end else if (bus.p1_req) begin
            p1_gnt_c = 1'b1;
            addr_c   = bus.p1_addr;
            we_c     = bus.p1_we;
            wdata_c  = bus.p1_wdata;
          end
        end
        SPLIT: begin
          if (bus.p1_req) begin
            p1_gnt_c = 1'b1;
            addr_c   = bus.p1_addr;
            we_c     = bus.p1_we;
            wdata_c  = bus.p1_wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.p0_gnt    = p0_gnt_c;
  assign bus.p1_gnt    = p1_gnt_c;
  assign bus.stall     = stall_c;
  assign bus.mem_addr  = addr_c;
  assign bus.mem_we    = we_c;
  assign bus.mem_wdata = wdata_c;

  // FSM: a conflict cycle moves to SPLIT and bumps the saturating counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      conflict_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (stall_c) begin
            state <= SPLIT;
            if (conflict_cnt != {CNT_W{1'b1}})
              conflict_cnt <= conflict_cnt + 1'b1;
          end
        end
        SPLIT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read return: a granted read is pending for one cycle, during which the
  // memory output is presented and then held for the lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0_pend    <= 1'b0;
      p1_pend    <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      p0_pend <= p0_gnt_c && !bus.p0_we;
      p1_pend <= p1_gnt_c && !bus.p1_we;
      if (p0_pend) p0_rdata_q <= bus.mem_rdata;
      if (p1_pend) p1_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.p0_rvalid = p0_pend;
  assign bus.p1_rvalid = p1_pend;
  assign bus.p0_rdata  = p0_pend ? bus.mem_rdata : p0_rdata_q;
  assign bus.p1_rdata  = p1_pend ? bus.mem_rdata : p1_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: drives lane bundles, models the data memory and checks the
// arbiter. Expected read data is pushed per lane when a bundle is driven and
// popped when that lane raises rvalid. A second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_dm_arbiter;
  localparam int AW    = 9;
  localparam int DW    = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             mem_preload = 1'b1;
  logic [CNT_W-1:0] conflict_cnt;
  logic [1:0]       sat_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [CNT_W-1:0] exp_cnt;
  logic [DW-1:0]    exp_data;
  logic [DW-1:0]    mem     [0:(1<<AW)-1];
  logic [DW-1:0]    ref_mem [0:(1<<AW)-1];
  logic [DW-1:0]    q0[$];
  logic [DW-1:0]    q1[$];

  dm_arbiter_if #(.AW(AW), .DW(DW)) bus();
  dm_arbiter_if #(.AW(AW), .DW(DW)) bus_sat();

  dm_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .conflict_cnt(conflict_cnt)
  );

  dm_arbiter #(.AW(AW), .DW(DW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus_sat), .conflict_cnt(sat_cnt)
  );

  assign bus_sat.p0_req    = bus.p0_req;
  assign bus_sat.p0_we     = bus.p0_we;
  assign bus_sat.p0_addr   = bus.p0_addr;
  assign bus_sat.p0_wdata  = bus.p0_wdata;
  assign bus_sat.p1_req    = bus.p1_req;
  assign bus_sat.p1_we     = bus.p1_we;
  assign bus_sat.p1_addr   = bus.p1_addr;
  assign bus_sat.p1_wdata  = bus.p1_wdata;
  assign bus_sat.mem_rdata = bus.mem_rdata;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pattern(input int i);
    return DW'(i * 37 + 16'h0100);
  endfunction

  // Single-port synchronous memory: read data valid one cycle after address.
  always @(posedge clk) begin
    if (mem_preload) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= pattern(i);
    end else begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] timeout");
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_lanes;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
  endtask

  // Drive a bundle and record its effect in program order, p0 then p1.
  task automatic drive_bundle(input logic r0, input logic w0,
                              input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic r1, input logic w1,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
    if (r0) begin
      if (w0) ref_mem[a0] = d0;
      else    q0.push_back(ref_mem[a0]);
    end
    if (r1) begin
      if (w1) ref_mem[a1] = d1;
      else    q1.push_back(ref_mem[a1]);
    end
  endtask

  task automatic pulse_reset;
    rst = 1'b0;
    idle_lanes();
    q0.delete();
    q1.delete();
    exp_cnt = '0;
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = pattern(i);
    exp_cnt = '0;
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 9'h0AA; bus.p0_wdata = 16'hFFFF;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 9'h155; bus.p1_wdata = 16'hFFFF;
    @(negedge clk);
    vectors++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we, bus.p0_rvalid, bus.p1_rvalid} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctl: got %b expected 000000",
               {bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we, bus.p0_rvalid, bus.p1_rvalid});
    end
    vectors++;
    if (bus.mem_addr !== 9'h000 || bus.mem_wdata !== 16'h0000 || conflict_cnt !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_bus: addr=%h wdata=%h cnt=%h expected all 0",
               bus.mem_addr, bus.mem_wdata, conflict_cnt);
    end
    next_cycle();
    mem_preload = 1'b0;
    rst = 1'b1;
    idle_lanes();
    @(negedge clk);
    vectors++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we} !== 4'b0 || conflict_cnt !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_release: ctl=%b cnt=%h expected 0000 and 0",
               {bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we}, conflict_cnt);
    end
    next_cycle();
  endtask

  task automatic test_single_write;
    drive_bundle(1'b1, 1'b1, 9'h005, 16'h0002, 1'b0, 1'b0, 9'h000, 16'h0000);
    @(negedge clk);
    vectors++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we} !== 4'b1001) begin
      miscompares++;
      $display("[TB] FAIL single_write_ctl: got %b expected 1001",
               {bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we});
    end
    vectors++;
    if (bus.mem_addr !== 9'h005 || bus.mem_wdata !== 16'h0002) begin
      miscompares++;
      $display("[TB] FAIL single_write_bus: addr=%h wdata=%h expected 005 0002",
               bus.mem_addr, bus.mem_wdata);
    end
    next_cycle();
    idle_lanes();
    @(negedge clk);
    vectors++;
    if ({bus.p0_rvalid, bus.p1_rvalid} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL single_write_rvalid: got %b expected 00", {bus.p0_rvalid, bus.p1_rvalid});
    end
    next_cycle();
  endtask

  task automatic test_write_read_conflict(input logic [DW-1:0] wval);
    drive_bundle(1'b1, 1'b1, 9'h005, wval, 1'b1, 1'b0, 9'h005, 16'h0000);
    @(negedge clk);
    vectors++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we} !== 4'b1011 ||
        bus.mem_addr !== 9'h005 || bus.mem_wdata !== wval) begin
      miscompares++;
      $display("[TB] FAIL conflict_cycle_n: ctl=%b addr=%h wdata=%h expected 1011 005 %h",
               {bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we}, bus.mem_addr, bus.mem_wdata, wval);
    end
    exp_cnt = exp_cnt + 1'b1;
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we} !== 4'b0100 || bus.mem_addr !== 9'h005) begin
      miscompares++;
      $display("[TB] FAIL conflict_cycle_n1: ctl=%b addr=%h expected 0100 005",
               {bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we}, bus.mem_addr);
    end
    vectors++;
    if (conflict_cnt !== exp_cnt) begin
      miscompares++;
      $display("[TB] FAIL conflict_cnt: got %0d expected %0d", conflict_cnt, exp_cnt);
    end
    next_cycle();
    idle_lanes();
    @(negedge clk);
    vectors++;
    if ({bus.p0_rvalid, bus.p1_rvalid} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL conflict_rvalid: got %b expected 01", {bus.p0_rvalid, bus.p1_rvalid});
    end
    exp_data = q1.pop_front();
    vectors++;
    if (bus.p1_rdata !== exp_data) begin
      miscompares++;
      $display("[TB] FAIL conflict_rdata: got %h expected %h", bus.p1_rdata, exp_data);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (bus.p1_rvalid !== 1'b0 || bus.p1_rdata !== exp_data) begin
      miscompares++;
      $display("[TB] FAIL rdata_hold: rvalid=%b rdata=%h expected 0 %h",
               bus.p1_rvalid, bus.p1_rdata, exp_data);
    end
    next_cycle();
  endtask

  task automatic test_both_read;
    drive_bundle(1'b1, 1'b1, 9'h010, 16'h00AB, 1'b0, 1'b0, 9'h000, 16'h0000);
    next_cycle();
    drive_bundle(1'b1, 1'b0, 9'h010, 16'h0000, 1'b1, 1'b0, 9'h010, 16'h0000);
    @(negedge clk);
`ifdef DM_ARB_MERGE_EN
    vectors++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we} !== 4'b1100 || bus.mem_addr !== 9'h010) begin
      miscompares++;
      $display("[TB] FAIL merge_read_grant: ctl=%b addr=%h expected 1100 010",
               {bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we}, bus.mem_addr);
    end
    next_cycle();
    idle_lanes();
    @(negedge clk);
    vectors++;
    if ({bus.p0_rvalid, bus.p1_rvalid} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL merge_read_rvalid: got %b expected 11", {bus.p0_rvalid, bus.p1_rvalid});
    end
    exp_data = q0.pop_front();
    vectors++;
    if (bus.p0_rdata !== exp_data) begin
      miscompares++;
      $display("[TB] FAIL merge_read_p0: got %h expected %h", bus.p0_rdata, exp_data);
    end
    exp_data = q1.pop_front();
    vectors++;
    if (bus.p1_rdata !== exp_data) begin
      miscompares++;
      $display("[TB] FAIL merge_read_p1: got %h expected %h", bus.p1_rdata, exp_data);
    end
`else
    vectors++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we} !== 4'b1010 || bus.mem_addr !== 9'h010) begin
      miscompares++;
      $display("[TB] FAIL split_read_n: ctl=%b addr=%h expected 1010 010",
               {bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we}, bus.mem_addr);
    end
    exp_cnt = exp_cnt + 1'b1;
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.stall, bus.p0_rvalid, bus.p1_rvalid} !== 5'b01010) begin
      miscompares++;
      $display("[TB] FAIL split_read_n1: got %b expected 01010",
               {bus.p0_gnt, bus.p1_gnt, bus.stall, bus.p0_rvalid, bus.p1_rvalid});
    end
    exp_data = q0.pop_front();
    vectors++;
    if (bus.p0_rdata !== exp_data) begin
      miscompares++;
      $display("[TB] FAIL split_read_p0: got %h expected %h", bus.p0_rdata, exp_data);
    end
    next_cycle();
    idle_lanes();
    @(negedge clk);
    vectors++;
    if ({bus.p0_rvalid, bus.p1_rvalid} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL split_read_n2: got %b expected 01", {bus.p0_rvalid, bus.p1_rvalid});
    end
    exp_data = q1.pop_front();
    vectors++;
    if (bus.p1_rdata !== exp_data) begin
      miscompares++;
      $display("[TB] FAIL split_read_p1: got %h expected %h", bus.p1_rdata, exp_data);
    end
`endif
    vectors++;
    if (conflict_cnt !== exp_cnt) begin
      miscompares++;
      $display("[TB] FAIL both_read_cnt: got %0d expected %0d", conflict_cnt, exp_cnt);
    end
    next_cycle();
  endtask

  task automatic test_both_write;
    drive_bundle(1'b1, 1'b1, 9'h020, 16'h1111, 1'b1, 1'b1, 9'h020, 16'h2222);
    @(negedge clk);
`ifdef DM_ARB_MERGE_EN
    vectors++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we} !== 4'b1101 || bus.mem_wdata !== 16'h2222) begin
      miscompares++;
      $display("[TB] FAIL merge_write: ctl=%b wdata=%h expected 1101 2222",
               {bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we}, bus.mem_wdata);
    end
`else
    vectors++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we} !== 4'b1011 || bus.mem_wdata !== 16'h1111) begin
      miscompares++;
      $display("[TB] FAIL split_write_n: ctl=%b wdata=%h expected 1011 1111",
               {bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we}, bus.mem_wdata);
    end
    exp_cnt = exp_cnt + 1'b1;
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we} !== 4'b0101 || bus.mem_wdata !== 16'h2222) begin
      miscompares++;
      $display("[TB] FAIL split_write_n1: ctl=%b wdata=%h expected 0101 2222",
               {bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we}, bus.mem_wdata);
    end
`endif
    next_cycle();
    drive_bundle(1'b1, 1'b0, 9'h020, 16'h0000, 1'b0, 1'b0, 9'h000, 16'h0000);
    next_cycle();
    idle_lanes();
    @(negedge clk);
    exp_data = q0.pop_front();
    vectors++;
    if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== exp_data) begin
      miscompares++;
      $display("[TB] FAIL write_order_readback: rvalid=%b rdata=%h expected 1 %h",
               bus.p0_rvalid, bus.p0_rdata, exp_data);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      a0 = AW'(9'h040 + i);
      a1 = AW'(9'h080 + i);
      drive_bundle(1'b1, 1'b0, a0, 16'h0000, 1'b1, 1'b0, a1, 16'h0000);
      @(negedge clk);
      vectors++;
      if (bus.stall !== 1'b1 || bus.p0_gnt !== 1'b1 || bus.mem_addr !== a0) begin
        miscompares++;
        $display("[TB] FAIL b2b_even_%0d: stall=%b p0_gnt=%b addr=%h expected 1 1 %h",
                 i, bus.stall, bus.p0_gnt, bus.mem_addr, a0);
      end
      if (i > 0) begin
        exp_data = q1.pop_front();
        vectors++;
        if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== exp_data) begin
          miscompares++;
          $display("[TB] FAIL b2b_p1_data_%0d: rvalid=%b rdata=%h expected 1 %h",
                   i, bus.p1_rvalid, bus.p1_rdata, exp_data);
        end
      end
      exp_cnt = exp_cnt + 1'b1;
      next_cycle();
      @(negedge clk);
      vectors++;
      if (bus.stall !== 1'b0 || bus.p1_gnt !== 1'b1 || bus.mem_addr !== a1) begin
        miscompares++;
        $display("[TB] FAIL b2b_odd_%0d: stall=%b p1_gnt=%b addr=%h expected 0 1 %h",
                 i, bus.stall, bus.p1_gnt, bus.mem_addr, a1);
      end
      exp_data = q0.pop_front();
      vectors++;
      if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== exp_data) begin
        miscompares++;
        $display("[TB] FAIL b2b_p0_data_%0d: rvalid=%b rdata=%h expected 1 %h",
                 i, bus.p0_rvalid, bus.p0_rdata, exp_data);
      end
      next_cycle();
    end
    idle_lanes();
    @(negedge clk);
    exp_data = q1.pop_front();
    vectors++;
    if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== exp_data) begin
      miscompares++;
      $display("[TB] FAIL b2b_p1_data_last: rvalid=%b rdata=%h expected 1 %h",
               bus.p1_rvalid, bus.p1_rdata, exp_data);
    end
    vectors++;
    if (conflict_cnt !== 16'd3) begin
      miscompares++;
      $display("[TB] FAIL b2b_cnt: got %0d expected 3", conflict_cnt);
    end
    next_cycle();
  endtask

  task automatic test_reset_in_split;
    drive_bundle(1'b1, 1'b0, 9'h030, 16'h0000, 1'b1, 1'b0, 9'h031, 16'h0000);
    @(negedge clk);
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_split_stall: got %b expected 1", bus.stall);
    end
    next_cycle();
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we, bus.p0_rvalid, bus.p1_rvalid} !== 6'b0 ||
        bus.mem_addr !== 9'h000 || bus.mem_wdata !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL rst_split_outputs: ctl=%b addr=%h wdata=%h expected 000000 000 0000",
               {bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we, bus.p0_rvalid, bus.p1_rvalid},
               bus.mem_addr, bus.mem_wdata);
    end
    vectors++;
    if (bus.p0_rdata !== 16'h0000 || bus.p1_rdata !== 16'h0000 || conflict_cnt !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL rst_split_data: p0=%h p1=%h cnt=%h expected 0 0 0",
               bus.p0_rdata, bus.p1_rdata, conflict_cnt);
    end
    q0.delete();
    q1.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b1;
    idle_lanes();
    next_cycle();
    drive_bundle(1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 9'h031, 16'h0000);
    @(negedge clk);
    vectors++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we} !== 4'b0100 || bus.mem_addr !== 9'h031) begin
      miscompares++;
      $display("[TB] FAIL rst_after_p1_grant: ctl=%b addr=%h expected 0100 031",
               {bus.p0_gnt, bus.p1_gnt, bus.stall, bus.mem_we}, bus.mem_addr);
    end
    next_cycle();
    idle_lanes();
    @(negedge clk);
    exp_data = q1.pop_front();
    vectors++;
    if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== exp_data) begin
      miscompares++;
      $display("[TB] FAIL rst_after_p1_read: rvalid=%b rdata=%h expected 1 %h",
               bus.p1_rvalid, bus.p1_rdata, exp_data);
    end
    next_cycle();
  endtask

  task automatic test_saturation;
    logic [1:0] exp_sat;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive_bundle(1'b1, 1'b1, AW'(9'h060 + i), DW'(16'hA000 + i),
                   1'b1, 1'b1, AW'(9'h070 + i), DW'(16'hB000 + i));
      next_cycle();
      exp_cnt = exp_cnt + 1'b1;
      exp_sat = (i >= 2) ? 2'd3 : 2'(i + 1);
      @(negedge clk);
      vectors++;
      if (sat_cnt !== exp_sat || conflict_cnt !== exp_cnt) begin
        miscompares++;
        $display("[TB] FAIL saturation_%0d: sat=%0d cnt=%0d expected %0d %0d",
                 i, sat_cnt, conflict_cnt, exp_sat, exp_cnt);
      end
      next_cycle();
    end
    idle_lanes();
    next_cycle();
  endtask

  initial begin
    idle_lanes();
    test_reset();
    test_single_write();
    test_write_read_conflict(16'h0002);
    test_write_read_conflict(16'h1234);
    test_both_read();
    test_both_write();
    test_back_to_back();
    test_reset_in_split();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
